// File: rtl/matrix_sub_sched.sv
// matrix_sub_sched: streams element pairs into the 16-lane subtractor array and returns one tile of differences at a time
module matrix_sub_sched #(
    parameter int LANES = 16,
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_tiles,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    output logic [2*LANES*W-1:0]   sub_op,
    input  logic [LANES*W-1:0]     sub_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*W-1:0]     out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    localparam int IW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] tiles, tile_cnt;
    logic [W-1:0]     op_a [LANES];
    logic [W-1:0]     op_b [LANES];

    // lane k occupies the k-th 32-bit slot from the top: A above B
    for (genvar k = 0; k < LANES; k++) begin : g_pack
        assign sub_op[2*LANES*W-1-2*W*k -: W]   = op_a[k];
        assign sub_op[2*LANES*W-1-W-2*W*k -: W] = op_b[k];
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && num_tiles != '0) state_nx = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx == IW'(LANES-1)) state_nx = EXEC;
            end
            EXEC: state_nx = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = out_last ? IDLE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // operand lanes, tile bookkeeping and the captured result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            tiles    <= '0;
            tile_cnt <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && num_tiles != '0) begin
                    tiles    <= num_tiles;
                    tile_cnt <= '0;
                    idx      <= '0;
                end
                LOAD: if (in_valid) begin
                    op_a[idx] <= in_a;
                    op_b[idx] <= in_b;
                    idx       <= (idx == IW'(LANES-1)) ? '0 : idx + 1'b1;
                end
                EXEC: begin
                    out_data <= sub_res;
                    out_last <= (tile_cnt == tiles - 1'b1);
                end
                DRAIN: if (out_ready) begin
                    out_last <= 1'b0;
                    tile_cnt <= tile_cnt + 1'b1;
                    done     <= out_last;
                end
                default: ;
            endcase
        end
    end
endmodule
